// File: rtl/dm_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and the default depth.
package dm_responder_pkg;

  localparam int DEPTH_W_DEFAULT = 12;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dm_lane_ext.sv
// Lane steering for one access: spreads store data across byte lanes with per-lane enables,
// and pulls the addressed byte/half out of a read word with sign or zero extension.
module dm_lane_ext
  import dm_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wlanes,
  output logic [3:0]  lane_we,
  output logic [31:0] rdata
);

  function automatic logic [31:0] extend(input logic [15:0] val, input logic is_half,
                                         input logic sgn);
    logic fill;
    fill = sgn & (is_half ? val[15] : val[7]);
    return is_half ? {{16{fill}}, val} : {{24{fill}}, val[7:0]};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword[{addr_lo, 3'b000} +: 8];
    half_sel = rword[{addr_lo[1], 4'b0000} +: 16];
    wlanes   = {4{wdata[7:0]}};
    lane_we  = 4'b0000;
    rdata    = '0;
    case (size)
      SZ_BYTE: begin
        lane_we = 4'b0001 << addr_lo;
        rdata   = extend({8'h00, byte_sel}, 1'b0, sign_ext);
      end
      SZ_HALF: begin
        wlanes  = {2{wdata[15:0]}};
        lane_we = addr_lo[1] ? 4'b1100 : 4'b0011;
        rdata   = extend(half_sel, 1'b1, sign_ext);
      end
      SZ_WORD: begin
        wlanes  = wdata;
        lane_we = 4'b1111;
        rdata   = rword;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder with a fixed response latency and a
// lane-writable word array; errors suppress writes and return zero data.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH_W = DEPTH_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);
  localparam int WORDS = 1 << DEPTH_W;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d, signed_q, signed_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem [WORDS];

  logic               cur_we, cur_signed, cur_err, commit, mem_wr;
  logic [1:0]         cur_size;
  logic [31:0]        cur_addr, cur_wdata, rword, wlanes, ext_rdata;
  logic [DEPTH_W-1:0] cur_idx;
  logic [3:0]         lane_we;

  // With LATENCY=0 the commit happens on the accept edge itself, so the live request is used.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we = req_we; cur_size = req_size; cur_signed = req_signed;
      cur_addr = req_addr; cur_wdata = req_wdata;
    end else begin
      cur_we = we_q; cur_size = size_q; cur_signed = signed_q;
      cur_addr = addr_q; cur_wdata = wdata_q;
    end
    cur_idx = cur_addr[DEPTH_W+1:2];
    cur_err = (cur_size == 2'b11)
           || (cur_size == SZ_HALF && cur_addr[0])
           || (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00)
           || ((cur_addr >> (DEPTH_W + 2)) != 32'd0);
  end

  assign rword = mem[cur_idx];

  dm_lane_ext u_lane (
    .size     (cur_size),
    .sign_ext (cur_signed),
    .addr_lo  (cur_addr[1:0]),
    .wdata    (cur_wdata),
    .rword    (rword),
    .wlanes   (wlanes),
    .lane_we  (lane_we),
    .rdata    (ext_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        we_d = req_we; size_d = req_size; signed_d = req_signed;
        addr_d = req_addr; wdata_d = req_wdata;
        if (LATENCY == 0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: if (cnt_q == 3'd0) begin
        state_d = ST_RESP;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      resp_err_d   = cur_err;
      resp_rdata_d = (cur_err || cur_we) ? 32'd0 : ext_rdata;
    end
    mem_wr = commit && cur_we && !cur_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q     <= we_d;
    size_q   <= size_d;
    signed_q <= signed_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
  end

  // Reset wins over a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (mem_wr) begin
      for (int l = 0; l < 4; l++)
        if (lane_we[l]) mem[cur_idx][8*l +: 8] <= wlanes[8*l +: 8];
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: directed loads/stores on a LATENCY=2 instance,
// plus latency-spacing runs on LATENCY=0 and LATENCY=7 instances.
module tb_dm_responder;
  import dm_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        v0, rdy0, rv0, re0, v7, rdy7, rv7, re7;
  logic [31:0] rd0, rd7;

  int errors = 0;
  int checks = 0;
  string cur_name = "none";

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  dm_responder #(.LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_rdata(rd0), .resp_err(re0)
  );

  dm_responder #(.LATENCY(7)) dut7 (
    .clk(clk), .reset(reset), .req_valid(v7), .req_ready(rdy7),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv7), .resp_ready(resp_ready),
    .resp_rdata(rd7), .resp_err(re7)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expectation.
  initial forever begin
    @(negedge clk);
    if (!reset && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        check({cur_name, "_unexpected_resp"}, 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check({cur_name, "_rdata"}, resp_rdata, mon_e.rdata);
        check({cur_name, "_err"}, {31'd0, resp_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int n;
    logic [31:0] held;
    cur_name = name;
    sb_q.push_back(exp_t'{rdata: exp_rdata, err: exp_err});
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_we = 1'b1;
    n = 1;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({name, "_latency"}, n, 32'd3);
    if (hold > 0) begin
      held = resp_rdata;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({name, "_bp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({name, "_bp_rdata"}, resp_rdata, held);
        check({name, "_bp_req_ready"}, {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({name, "_req_ready_after"}, {31'd0, req_ready}, 32'd1);
    check({name, "_valid_after"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic lat_check(input int which, input int lat);
    int acc, resps;
    logic rdy, vld, er;
    logic [31:0] rd;
    string nm;
    nm = (which == 0) ? "lat0" : "lat7";
    acc = -1;
    resps = 0;
    if (which == 0) v0 = 1'b1; else v7 = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      rdy = (which == 0) ? rdy0 : rdy7;
      vld = (which == 0) ? rv0 : rv7;
      rd  = (which == 0) ? rd0 : rd7;
      er  = (which == 0) ? re0 : re7;
      if (vld) begin
        resps++;
        check({nm, "_spacing"}, cyc - acc, lat + 1);
        check({nm, "_rdata"}, rd, 32'd0);
        check({nm, "_err"}, {31'd0, er}, 32'd0);
      end
      if (rdy) acc = cyc;
    end
    v0 = 1'b0;
    v7 = 1'b0;
    check({nm, "_resp_count_ge3"}, {31'd0, resps >= 3}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1; v0 = 1'b0; v7 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);

    issue("sw_10",      1, SZ_WORD, 0, 32'h10, 32'h8000_12F4, 32'h0,          0, 0);
    issue("lb_10",      0, SZ_BYTE, 1, 32'h10, 32'h0,         32'hFFFF_FFF4,  0, 0);
    issue("lbu_11",     0, SZ_BYTE, 0, 32'h11, 32'h0,         32'h0000_0012,  0, 0);
    issue("lb_13",      0, SZ_BYTE, 1, 32'h13, 32'h0,         32'hFFFF_FF80,  0, 0);
    issue("lhu_12",     0, SZ_HALF, 0, 32'h12, 32'h0,         32'h0000_8000,  0, 0);
    issue("lh_10",      0, SZ_HALF, 1, 32'h10, 32'h0,         32'h0000_12F4,  0, 0);
    issue("lw_10_sgn",  0, SZ_WORD, 1, 32'h10, 32'h0,         32'h8000_12F4,  0, 0);
    issue("sh_22",      1, SZ_HALF, 0, 32'h22, 32'h1234_ABCD, 32'h0,          0, 0);
    issue("lw_20",      0, SZ_WORD, 0, 32'h20, 32'h0,         32'hABCD_0000,  0, 0);
    issue("lhu_22",     0, SZ_HALF, 0, 32'h22, 32'h0,         32'h0000_ABCD,  0, 0);
    issue("lh_22",      0, SZ_HALF, 1, 32'h22, 32'h0,         32'hFFFF_ABCD,  0, 0);
    issue("sb_21",      1, SZ_BYTE, 0, 32'h21, 32'h0000_FF5A, 32'h0,          0, 0);
    issue("lw_20_b",    0, SZ_WORD, 0, 32'h20, 32'h0,         32'hABCD_5A00,  0, 0);
    issue("lw_mis_6",   0, SZ_WORD, 0, 32'h6,  32'h0,         32'h0,          1, 0);
    issue("sw_oor",     1, SZ_WORD, 0, 32'h0001_0000, 32'h1234_5678, 32'h0,   1, 0);
    issue("lw_0",       0, SZ_WORD, 0, 32'h0,  32'h0,         32'h0,          0, 0);
    issue("sh_mis_1",   1, SZ_HALF, 0, 32'h1,  32'hFFFF,      32'h0,          1, 0);
    issue("ld_sz11",    0, 2'b11,   0, 32'h10, 32'h0,         32'h0,          1, 0);
    issue("sb_top",     1, SZ_BYTE, 0, 32'h3FFF, 32'h77,      32'h0,          0, 0);
    issue("lbu_top",    0, SZ_BYTE, 0, 32'h3FFF, 32'h0,       32'h0000_0077,  0, 0);
    issue("lw_4000",    0, SZ_WORD, 0, 32'h4000, 32'h0,       32'h0,          1, 0);
    resp_ready = 1'b0;
    issue("lw_20_bp",   0, SZ_WORD, 0, 32'h20, 32'h0,         32'hABCD_5A00,  0, 5);

    // Abort a store while it is waiting out its latency.
    cur_name = "abort";
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_in_wait_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_rdata_cleared", resp_rdata, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      check("abort_idle", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
    end
    issue("lw_40_after", 0, SZ_WORD, 0, 32'h40, 32'h0, 32'h0, 0, 0);
    issue("lw_20_clr",   0, SZ_WORD, 0, 32'h20, 32'h0, 32'h0, 0, 0);

    req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    lat_check(0, 0);
    lat_check(1, 7);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
